// File: rtl/invert_flag_reg.sv
// Holds the seen_one flag of the bit-serial two's-complement negator.
// The flag records that a 1 has already been sampled in the current word
// and stays set until a synchronous reset starts a new word.
module invert_flag_reg (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    output logic flag_o
);

    logic flag_q;
    logic flag_d;

    // Next state: once a 1 is seen the flag latches high for the rest of the word.
    always_comb begin
        flag_d = flag_q | set_i;
    end

    // Flag register with synchronous active-high reset; reset wins over a same-cycle 1.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/invert.sv
// Bit-serial two's-complement negator, LSB first.
// Bits pass unchanged up to and including the first 1; every later bit is
// inverted. The output is Mealy (same cycle as the input bit); a word
// boundary exists only where r is asserted.
module invert (
    input  logic t_clk,
    input  logic r,
    input  logic i,
    output logic y
);

    logic seen_one;

    invert_flag_reg u_flag (
        .clk_i  (t_clk),
        .rst_i  (r),
        .set_i  (i),
        .flag_o (seen_one)
    );

    // Output bit: the current flag value decides pass-through or inversion,
    // also during the reset cycle itself.
    always_comb begin
        y = i ^ seen_one;
    end

endmodule

// File: tb/tb_invert.sv
// Directed bench for the bit-serial two's-complement negator.
// Inputs change on the falling edge; y is checked before the next rising edge.
module tb_invert;

    logic t_clk;
    logic r;
    logic i;
    logic y;

    int checks = 0;
    int errors = 0;

    invert dut (
        .t_clk (t_clk),
        .r     (r),
        .i     (i),
        .y     (y)
    );

    initial begin
        t_clk = 1'b0;
        forever #78 t_clk = ~t_clk;
    end

    // Drive one (i, r) pair half a period away from the rising edge and check y.
    task automatic step(input logic in_i, input logic in_r, input logic exp_y,
                        input string tag);
        @(negedge t_clk);
        i = in_i;
        r = in_r;
        #40;
        checks++;
        assert (y === exp_y) else begin
            errors++;
            $error("FAIL %s: y=%b expected %b", tag, y, exp_y);
        end
    endtask

    // Drive one cycle without checking (used only before the first reset edge).
    task automatic drive(input logic in_i, input logic in_r);
        @(negedge t_clk);
        i = in_i;
        r = in_r;
    endtask

    initial begin
        i = 1'b0;
        r = 1'b1;

        // Initial reset; flag is undefined until this edge.
        drive(1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, "reset_y_eq_i_0");
        step(1'b1, 1'b1, 1'b1, "reset_y_eq_i_1");

        // Word 0b0010 -> 0b1110
        step(1'b0, 1'b1, 1'b0, "w2_reset");
        step(1'b0, 1'b0, 1'b0, "w2_b0");
        step(1'b1, 1'b0, 1'b1, "w2_b1");
        step(1'b0, 1'b0, 1'b1, "w2_b2");
        step(1'b0, 1'b0, 1'b1, "w2_b3");

        // Word 0b0110 -> 0b1010 (reset cycle shows inverted old-word bit)
        step(1'b0, 1'b1, 1'b1, "w6_reset_old_flag");
        step(1'b0, 1'b0, 1'b0, "w6_b0");
        step(1'b1, 1'b0, 1'b1, "w6_b1");
        step(1'b1, 1'b0, 1'b0, "w6_b2");
        step(1'b0, 1'b0, 1'b1, "w6_b3");

        // Mid-word reset with i=1: reset wins, next 1 is treated as the first 1
        step(1'b1, 1'b1, 1'b0, "mid_reset_r1_i1");
        step(1'b1, 1'b0, 1'b1, "mid_first_one");
        step(1'b0, 1'b0, 1'b1, "mid_after_one");

        // All-zero word -> all-zero output, flag stays clear
        step(1'b0, 1'b1, 1'b1, "z_reset");
        step(1'b0, 1'b0, 1'b0, "z_b0");
        step(1'b0, 1'b0, 1'b0, "z_b1");
        step(1'b0, 1'b0, 1'b0, "z_b2");
        step(1'b0, 1'b0, 1'b0, "z_b3");
        checks++;
        assert (dut.seen_one === 1'b0) else begin
            errors++;
            $error("FAIL z_flag: seen_one=%b expected 0", dut.seen_one);
        end

        // Full sequence from the reference table, all cycles after the first checked
        step(1'b0, 1'b1, 1'b0, "seq_c0");
        step(1'b1, 1'b1, 1'b1, "seq_c1");
        step(1'b0, 1'b0, 1'b0, "seq_c2");
        step(1'b1, 1'b0, 1'b1, "seq_c3");
        step(1'b0, 1'b0, 1'b1, "seq_c4");
        step(1'b1, 1'b1, 1'b0, "seq_c5");
        step(1'b1, 1'b0, 1'b1, "seq_c6");
        step(1'b0, 1'b0, 1'b1, "seq_c7");
        step(1'b1, 1'b0, 1'b0, "seq_c8");
        step(1'b0, 1'b0, 1'b1, "seq_c9");
        step(1'b0, 1'b0, 1'b1, "seq_c10");
        step(1'b1, 1'b0, 1'b0, "seq_c11");
        step(1'b1, 1'b0, 1'b0, "seq_c12");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
